// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - RV32IM execute stage: single-cycle ALU plus iterative multiply/divide
module exe_stage #(
    parameter int unsigned MD_ENABLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [125:0] id_exe_bus_in,
    input  logic         flush_in,
    output logic         stall_out,
    output logic [74:0]  exe_mem_bus_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [125:0] ex_q, ex_d;
    logic [74:0]  out_q, out_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  hi_q, hi_d;
    logic [31:0]  lo_q, lo_d;
    logic [31:0]  mdop_q, mdop_d;
    logic         neg_res_q, neg_res_d;
    logic         neg_rem_q, neg_rem_d;

    logic         md_load;
    logic         md_step;

    // Fields of the instruction held in EX
    logic [31:0]  op1, op2, pc;
    logic [4:0]   rd;
    logic         rd_wen, mem_we, mem_re;
    logic [2:0]   wb_sel;
    logic [18:0]  fun, fun_lo;
    logic         m_raw, m_op, is_div;

    assign op1    = ex_q[125:94];
    assign op2    = ex_q[93:62];
    assign rd     = ex_q[61:57];
    assign rd_wen = ex_q[56];
    assign fun    = ex_q[55:37];
    assign mem_we = ex_q[36];
    assign mem_re = ex_q[35];
    assign wb_sel = ex_q[34:32];
    assign pc     = ex_q[31:0];

    // Isolating the lowest set bit makes a malformed multi-hot code resolve to the lowest index
    assign fun_lo = fun & (~fun + 19'd1);
    assign m_raw  = |fun_lo[18:11];
    assign m_op   = (MD_ENABLE != 0) && m_raw;
    assign is_div = |fun_lo[18:15];

    // Operand signedness and magnitudes for the multiply/divide core
    logic        s1, s2, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign s1    = fun_lo[11] | fun_lo[12] | fun_lo[13] | fun_lo[15] | fun_lo[17];
    assign s2    = fun_lo[11] | fun_lo[12] | fun_lo[15] | fun_lo[17];
    assign a_neg = s1 & op1[31];
    assign b_neg = s2 & op2[31];
    assign a_mag = a_neg ? (~op1 + 32'd1) : op1;
    assign b_mag = b_neg ? (~op2 + 32'd1) : op2;

    // One radix-2 step: shift-add multiply and restoring divide
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mdop_q} : 33'd0);
    assign div_shift = {hi_q, lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mdop_q};
    assign div_diff  = div_shift[31:0] - mdop_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m_op) state_d = BUSY;
            BUSY:    if (cnt_q == 5'd31) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_in) begin
            state_d = IDLE;
        end
    end

    // FSM outputs: stall upstream and steer the multiply/divide datapath
    always_comb begin
        stall_out = 1'b0;
        md_load   = 1'b0;
        md_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_op) begin
                    stall_out = 1'b1;
                    md_load   = 1'b1;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                md_step   = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiply/divide iteration registers: load magnitudes, then 32 steps
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mdop_d    = mdop_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (flush_in) begin
            hi_d      = '0;
            lo_d      = '0;
            mdop_d    = '0;
            cnt_d     = '0;
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
        end else if (md_load) begin
            hi_d      = '0;
            cnt_d     = '0;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (is_div) begin
                lo_d   = a_mag;
                mdop_d = b_mag;
            end else begin
                lo_d   = b_mag;
                mdop_d = a_mag;
            end
        end else if (md_step) begin
            cnt_d = cnt_q + 5'd1;
            if (is_div) begin
                hi_d = div_ge ? div_diff : div_shift[31:0];
                lo_d = {lo_q[30:0], div_ge};
            end else begin
                hi_d = mul_sum[32:1];
                lo_d = {mul_sum[0], lo_q[31:1]};
            end
        end
    end

    // Final multiply/divide result with sign fix-up and division special cases
    logic [63:0] prod, prod_s;
    logic [31:0] quo, rem, md_res;
    logic        div_zero, div_ovf;

    assign prod     = {hi_q, lo_q};
    assign prod_s   = neg_res_q ? (~prod + 64'd1) : prod;
    assign quo      = neg_res_q ? (~lo_q + 32'd1) : lo_q;
    assign rem      = neg_rem_q ? (~hi_q + 32'd1) : hi_q;
    assign div_zero = (op2 == 32'd0);
    assign div_ovf  = (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

    // Select the M-extension result for the op held in EX
    always_comb begin
        md_res = '0;
        if (fun_lo[11]) begin
            md_res = prod_s[31:0];
        end else if (fun_lo[12] | fun_lo[13] | fun_lo[14]) begin
            md_res = prod_s[63:32];
        end else if (fun_lo[15]) begin
            md_res = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : quo);
        end else if (fun_lo[16]) begin
            md_res = div_zero ? 32'hFFFF_FFFF : quo;
        end else if (fun_lo[17]) begin
            md_res = div_zero ? op1 : (div_ovf ? 32'd0 : rem);
        end else if (fun_lo[18]) begin
            md_res = div_zero ? op1 : rem;
        end
    end

    // Single-cycle ALU
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        if      (fun_lo[0])  alu_res = op1 + op2;
        else if (fun_lo[1])  alu_res = op1 - op2;
        else if (fun_lo[2])  alu_res = op1 & op2;
        else if (fun_lo[3])  alu_res = op1 | op2;
        else if (fun_lo[4])  alu_res = op1 ^ op2;
        else if (fun_lo[5])  alu_res = op1 << op2[4:0];
        else if (fun_lo[6])  alu_res = op1 >> op2[4:0];
        else if (fun_lo[7])  alu_res = $unsigned($signed(op1) >>> op2[4:0]);
        else if (fun_lo[8])  alu_res = {31'd0, $signed(op1) < $signed(op2)};
        else if (fun_lo[9])  alu_res = {31'd0, op1 < op2};
        else if (fun_lo[10]) alu_res = op1;
    end

    // Next EX register and output bus; bubbles while stalled or flushed
    always_comb begin
        ex_d = stall_out ? ex_q : id_exe_bus_in;
        if (flush_in) begin
            ex_d = '0;
        end
        out_d = {alu_res, rd, rd_wen, mem_we, mem_re, wb_sel, pc};
        if (flush_in) begin
            out_d = '0;
        end else if (state_q == DONE) begin
            out_d = {md_res, rd, rd_wen, mem_we, mem_re, wb_sel, pc};
        end else if (stall_out) begin
            out_d = '0;
        end else if (m_raw) begin
            // Only reachable with the M-extension disabled: pass fields, never write back
            out_d = {32'd0, rd, 1'b0, mem_we, mem_re, wb_sel, pc};
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mdop_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mdop_q    <= mdop_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign exe_mem_bus_out = out_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard testbench for exe_stage
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [125:0] id_bus = '0;
    logic         flush_in = 1'b0;
    logic         stall_out;
    logic [74:0]  exe_mem_bus_out;

    exe_stage #(.MD_ENABLE(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_exe_bus_in   (id_bus),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .exe_mem_bus_out (exe_mem_bus_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cap_cyc = 0;
    int last_pop = 0;
    logic [31:0] pc_n = 32'h0000_0100;

    logic [74:0] exp_q[$];
    string       tag_q[$];
    int          pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [74:0] got, input logic [74:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] fb(input int idx);
        logic [18:0] one;
        one = 19'd1;
        return one << idx;
    endfunction

    function automatic logic [125:0] mk_id(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] rd, input logic [18:0] fun,
                                           input logic [31:0] pc);
        return {a, b, rd, 1'b1, fun, 1'b0, 1'b0, 3'd2, pc};
    endfunction

    function automatic logic [74:0] mk_exp(input logic [31:0] res, input logic [4:0] rd,
                                           input logic [31:0] pc);
        return {res, rd, 1'b1, 1'b0, 1'b0, 3'd2, pc};
    endfunction

    // Reference model built on wide native arithmetic
    function automatic logic [31:0] ref_alu(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        p  = '0;
        case (idx)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << b[4:0];
            6:  return a >> b[4:0];
            7:  return 32'($signed(a) >>> b[4:0]);
            8:  return {31'd0, $signed(a) < $signed(b)};
            9:  return {31'd0, a < b};
            10: return a;
            11: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            12: begin p = sa * sb; return p[63:32]; end
            13: begin p = sa * ub; return p[63:32]; end
            14: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            15: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            17: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            18: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Output monitor: every non-bubble result must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && exe_mem_bus_out != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", exe_mem_bus_out, '0);
            end else begin
                check_eq(tag_q.pop_front(), exe_mem_bus_out, exp_q.pop_front());
                pop_cyc.push_back(cyc);
                last_pop = cyc;
            end
        end
    end

    // Drive one instruction, honour stall_out, return at the negedge after capture
    task automatic send(input logic [125:0] b, input logic push, input logic [74:0] e, input string tag);
        int n;
        n = 0;
        id_bus = b;
        if (push) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        while (stall_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall_out) check_eq({tag, "_send_timeout"}, {74'd0, stall_out}, '0);
        @(negedge clk);
        cap_cyc = cyc;
        id_bus = '0;
    endtask

    task automatic issue(input string tag, input logic [18:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res);
        logic [4:0] rd;
        pc_n = pc_n + 32'd4;
        rd = pc_n[6:2];
        send(mk_id(a, b, rd, fun, pc_n), 1'b1, mk_exp(res, rd, pc_n), tag);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq({tag, "_drain_timeout"}, 75'(exp_q.size()), '0);
            exp_q.delete();
            tag_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_eq("rst_out", exe_mem_bus_out, '0);
        check_eq("rst_stall", {74'd0, stall_out}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU basics with latency
        issue("add_ovf", fb(0), 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        wait_drain("add");
        check_eq("add_latency", 75'(last_pop - cap_cyc), 75'd1);
        issue("sra", fb(7), 32'h8000_0000, 32'h24, 32'hF800_0000);
        issue("multi_hot_or", fb(3) | fb(11) | fb(15), 32'h00F0, 32'h0F00, 32'h0FF0);
        issue("sltu", fb(9), 32'd1, 32'hFFFF_FFFF, 32'd1);
        issue("slt", fb(8), 32'd1, 32'hFFFF_FFFF, 32'd0);
        wait_drain("alu");

        // MULH: stall length, bubbles, latency
        issue("mulh", fb(12), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        n = 0;
        while (stall_out && n < 100) begin
            check_eq("mulh_bubble", exe_mem_bus_out, '0);
            n++;
            @(negedge clk);
        end
        check_eq("mulh_stall_cycles", 75'(n), 75'd33);
        wait_drain("mulh");
        check_eq("mulh_latency", 75'(last_pop - cap_cyc), 75'd34);
        issue("mulhu", fb(14), 32'hFFFF_FFFF, 32'd2, 32'd1);
        issue("mul", fb(11), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        issue("div_neg", fb(15), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue("rem_neg", fb(17), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        issue("divu_zero", fb(16), 32'h55, 32'd0, 32'hFFFF_FFFF);
        issue("remu_zero", fb(18), 32'h1234, 32'd0, 32'h1234);
        issue("div_ovf", fb(15), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue("rem_ovf", fb(17), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_drain("md");

        // Back-to-back ADD, DIVU, SUB
        pop_cyc.delete();
        issue("b2b_add", fb(0), 32'd10, 32'd20, 32'd30);
        issue("b2b_divu", fb(16), 32'd100, 32'd7, 32'd14);
        issue("b2b_sub", fb(1), 32'd5, 32'd9, 32'hFFFF_FFFC);
        wait_drain("b2b");
        check_eq("b2b_count", 75'(pop_cyc.size()), 75'd3);
        if (pop_cyc.size() == 3) begin
            check_eq("b2b_sub_gap", 75'(pop_cyc[2] - pop_cyc[1]), 75'd1);
            check_eq("b2b_divu_gap", 75'(pop_cyc[1] - pop_cyc[0]), 75'd34);
        end

        // Flush a MUL at iteration 10
        send(mk_id(32'd3, 32'd4, 5'd7, fb(11), 32'h0000_0F00), 1'b0, '0, "mul_flushed");
        repeat (11) @(negedge clk);
        check_eq("flush_pre_stall", {74'd0, stall_out}, 75'd1);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        check_eq("flush_stall", {74'd0, stall_out}, '0);
        check_eq("flush_out", exe_mem_bus_out, '0);
        issue("post_flush_add", fb(0), 32'd1, 32'd2, 32'd3);
        wait_drain("flush");
        check_eq("post_flush_latency", 75'(last_pop - cap_cyc), 75'd1);

        // Reset in the middle of a DIV
        send(mk_id(32'd1000, 32'd3, 5'd9, fb(15), 32'h0000_0E00), 1'b0, '0, "div_reset");
        repeat (5) @(negedge clk);
        check_eq("div_pre_rst_stall", {74'd0, stall_out}, 75'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_stall", {74'd0, stall_out}, '0);
        check_eq("async_rst_out", exe_mem_bus_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst_add", fb(0), 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        wait_drain("rst");
        check_eq("post_rst_latency", 75'(last_pop - cap_cyc), 75'd1);

        // Mixed random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            int idx;
            logic [31:0] a, b;
            idx = int'($urandom_range(0, 18));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
            issue($sformatf("rnd%0d_op%0d", i, idx), fb(idx), a, b, ref_alu(idx, a, b));
        end
        wait_drain("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline. Sits directly downstream of the decode stage and consumes its 126-bit id_exe bus.
- Registers the bus, performs single-cycle ALU ops and iterative 32-cycle multiply/divide, and drives a registered 75-bit exe_mem bus to the memory stage.
- Asserts stall_out to freeze upstream while an M-extension op is in flight.

Parameters:
- MD_ENABLE, 1, 1 = M-ops executed iteratively; 0 = any M-op bit is treated as a bubble (no stall, outputs zero/disabled).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_exe_bus_in  in  126  {op1[125:94], op2[93:62], rd[61:57], rd_wen[56], exe_fun[55:37], mem_we[36], mem_re[35], wb_sel[34:32], pc[31:0]}
- flush_in  in  1  synchronous kill of the instruction held in EX
- stall_out  out  1  upstream must hold id_exe_bus_in stable while high
- exe_mem_bus_out  out  75  {alu_out[74:43], rd[42:38], rd_wen[37], mem_we[36], mem_re[35], wb_sel[34:32], pc[31:0]}

Behaviour:
- exe_fun is one-hot:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 COPY1 (alu_out = op1)
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU
  - All-zero = bubble, alu_out = 0. If multiple bits are set, the lowest index wins.
- Shifts use op2[4:0]. SLT is signed, SLTU unsigned; result is 0 or 1. All arithmetic is mod 2^32.
- Reset: ex register, exe_mem_bus_out, multiply/divide state, counter and partial results all 0. State = IDLE. stall_out = 0.
- EX register capture: loads id_exe_bus_in on every edge where stall_out = 0. It holds while stall_out = 1.
- Non-M op latency: bus captured at edge E0, result appears on exe_mem_bus_out after E1 (1-cycle stage).
- M-op state machine:
  - IDLE: EX holds an M-op → stall_out = 1. Next edge: load operand magnitudes and sign flags, cnt = 0 → BUSY.
  - BUSY: one radix-2 step per edge (shift-add for MUL*, restoring divide for DIV*/REM*). After the step with cnt = 31 → DONE.
  - DONE: stall_out = 0, final result driven. Next edge: output registered, EX accepts the next instruction → IDLE.
  - Timing: stall_out is high for exactly 33 cycles after capture. Result appears on exe_mem_bus_out 34 edges after capture.
  - Latency is fixed at 32 iterations regardless of operand values.
- While stall_out = 1, each edge writes a bubble to exe_mem_bus_out: alu_out = 0, rd = 0, rd_wen = 0, mem_we = 0, mem_re = 0, wb_sel = 0, pc = 0.
- Sign handling:
  - MUL/MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - The unsigned core result is negated when the operand signs differ (quotient). The remainder takes the sign of the dividend.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Division special cases (overrides the iterative result, same latency):
  - Divisor = 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = op1.
  - DIV of 0x80000000 by 0xFFFFFFFF: quotient = 0x80000000, REM = 0.
- flush_in = 1 at an edge:
  - EX register cleared to bubble, state → IDLE, cnt = 0.
  - Output register gets a bubble.
  - stall_out low in the following cycle.
  - flush has priority over capture and over iteration.
- Reset asserted mid-operation: immediate return to reset values. No partial result ever reaches the output.
- MD_ENABLE = 0: M-op bits are ignored. The op produces a bubble, except that rd/pc/control fields pass with rd_wen forced 0.

Test Plan:
- ADD: op1 = 0x7FFFFFFF, op2 = 1, rd = 5, rd_wen = 1 → one cycle later alu_out = 0x80000000, rd = 5, rd_wen = 1, pc passed through. Then SRA: op1 = 0x80000000, op2 = 0x24 → alu_out = 0xF8000000.
- MULH: op1 = 0xFFFFFFFF (-1), op2 = 0x00000002 → stall_out high exactly 33 cycles, bubbles output meanwhile, then alu_out = 0xFFFFFFFF. MULHU with the same operands → 0x00000001. MUL → 0xFFFFFFFE.
- DIV/REM with op1 = -7 (0xFFFFFFF9), op2 = 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU by 0 → 0xFFFFFFFF. REMU by 0 with op1 = 0x1234 → 0x1234. DIV 0x80000000 / -1 → 0x80000000.
- Back-to-back: ADD, DIVU, SUB sent with upstream honouring stall_out → three results in order, no duplication or loss; the SUB result appears 1 cycle after the DIVU result.
- flush_in pulsed at iteration 10 of a MUL → state IDLE, stall_out low next cycle, bubble output, the next instruction is captured normally.
- rst_n dropped mid-DIV → all outputs 0 asynchronously. After release, the first ADD completes with 1-cycle latency.
